// File: rtl/alu_seq_param.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_param
//  Description : Registered execute-stage ALU with a valid/ready input
//                handshake. Single-cycle logic/arith/shift/compare ops, plus
//                an optional iterative MUL/DIVU/REMU unit (shift-add multiply,
//                restoring divide) enabled by the ALU_MULDIV_EN macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_param #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUOp,
  output logic             out_valid,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH) + 1;

  localparam logic [3:0] c_OP_AND  = 4'b0000;
  localparam logic [3:0] c_OP_OR   = 4'b0001;
  localparam logic [3:0] c_OP_ADD  = 4'b0010;
  localparam logic [3:0] c_OP_XOR  = 4'b0011;
  localparam logic [3:0] c_OP_SLL  = 4'b0100;
  localparam logic [3:0] c_OP_SRL  = 4'b0101;
  localparam logic [3:0] c_OP_SUB  = 4'b0110;
  localparam logic [3:0] c_OP_SLT  = 4'b0111;
  localparam logic [3:0] c_OP_SLTU = 4'b1000;
  localparam logic [3:0] c_OP_SRA  = 4'b1001;
  localparam logic [3:0] c_OP_MUL  = 4'b1010;
  localparam logic [3:0] c_OP_DIVU = 4'b1011;
  localparam logic [3:0] c_OP_NOR  = 4'b1100;
  localparam logic [3:0] c_OP_REMU = 4'b1101;

  logic             w_accept;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_alu;
  logic             w_alu_illegal;
  logic             w_is_mc;
  logic             w_mc_done;
  logic [WIDTH-1:0] w_mc_result;
  logic [WIDTH-1:0] r_result;
  logic             r_illegal;
  logic             r_out_valid;

  // flush squashes any op presented in the same cycle
  assign w_accept = in_valid & in_ready & ~flush;
  assign w_shamt  = b[SHW-1:0];

  // Single-cycle result and op classification
  always_comb begin
    w_alu         = '0;
    w_alu_illegal = 1'b0;
    w_is_mc       = 1'b0;
    case (ALUOp)
      c_OP_AND:  w_alu = a & b;
      c_OP_OR:   w_alu = a | b;
      c_OP_ADD:  w_alu = a + b;
      c_OP_SUB:  w_alu = a - b;
      c_OP_NOR:  w_alu = ~(a | b);
      c_OP_XOR:  w_alu = a ^ b;
      c_OP_SLL:  w_alu = a << w_shamt;
      c_OP_SRL:  w_alu = a >> w_shamt;
      c_OP_SRA:  w_alu = $signed(a) >>> w_shamt;
      c_OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      c_OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_MULDIV_EN
      c_OP_MUL, c_OP_DIVU, c_OP_REMU: w_is_mc = 1'b1;
`endif
      default:   w_alu_illegal = 1'b1;
    endcase
  end

`ifdef ALU_MULDIV_EN
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_count;
  logic             r_is_mul;
  logic             r_sel_quot;
  // r_acc: product accumulator (MUL) or partial remainder (DIV)
  // r_opa: shifting multiplicand (MUL) or dividend/quotient (DIV)
  // r_opb: shifting multiplier (MUL) or divisor (DIV)
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_opa_nxt;
  logic [WIDTH-1:0] w_opb_nxt;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_diff;

  assign in_ready    = (r_state == S_IDLE);
  assign w_mc_done   = (r_state == S_BUSY) && (r_count == CW'(1));
  assign w_mc_result = r_sel_quot ? w_opa_nxt : w_acc_nxt;

  // One multiply or divide iteration
  always_comb begin
    w_acc_nxt = r_acc;
    w_opa_nxt = r_opa;
    w_opb_nxt = r_opb;
    w_shifted = {r_acc, r_opa[WIDTH-1]};
    // Top bit set means the trial subtraction borrowed (restore)
    w_diff    = w_shifted - {1'b0, r_opb};
    if (r_is_mul) begin
      if (r_opb[0]) w_acc_nxt = r_acc + r_opa;
      w_opa_nxt = r_opa << 1;
      w_opb_nxt = r_opb >> 1;
    end else if (!w_diff[WIDTH]) begin
      w_acc_nxt = w_diff[WIDTH-1:0];
      w_opa_nxt = {r_opa[WIDTH-2:0], 1'b1};
    end else begin
      w_acc_nxt = w_shifted[WIDTH-1:0];
      w_opa_nxt = {r_opa[WIDTH-2:0], 1'b0};
    end
  end

  // FSM next-state: IDLE until a multi-cycle op, BUSY until last iteration or flush
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_mc) w_state_nxt = S_BUSY;
      S_BUSY:  if (flush || w_mc_done)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Iteration datapath: load operands on accept, step while busy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_is_mul   <= 1'b0;
      r_sel_quot <= 1'b0;
      r_acc      <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
    end else if (w_accept && w_is_mc) begin
      r_count    <= CW'(WIDTH);
      r_is_mul   <= (ALUOp == c_OP_MUL);
      r_sel_quot <= (ALUOp == c_OP_DIVU);
      r_acc      <= '0;
      r_opa      <= a;
      r_opb      <= b;
    end else if (flush) begin
      r_count    <= '0;
    end else if (r_state == S_BUSY) begin
      r_count    <= r_count - CW'(1);
      r_acc      <= w_acc_nxt;
      r_opa      <= w_opa_nxt;
      r_opb      <= w_opb_nxt;
    end
  end
`else
  assign in_ready    = 1'b1;
  assign w_mc_done   = 1'b0;
  assign w_mc_result = '0;
`endif

  // Output registers: capture single-cycle results or the final iteration
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result    <= '0;
      r_illegal   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_mc_done) begin
        r_result    <= w_mc_result;
        r_illegal   <= 1'b0;
        r_out_valid <= 1'b1;
      end else if (w_accept && !w_is_mc) begin
        r_result    <= w_alu;
        r_illegal   <= w_alu_illegal;
        r_out_valid <= 1'b1;
      end
    end
  end

  assign Result    = r_result;
  assign Zero      = (r_result == '0);
  assign illegal   = r_illegal;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq_param
//  Description : Directed self-checking bench for alu_seq_param (WIDTH=64).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic [3:0]  ALUOp = '0;
  logic        out_valid;
  logic [63:0] Result;
  logic        Zero;
  logic        illegal;

  int checks = 0;
  int failures = 0;

  alu_seq_param #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .ALUOp(ALUOp), .out_valid(out_valid),
    .Result(Result), .Zero(Zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Present one op for exactly one edge; returns 1ns after that edge
  task automatic send(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
    @(negedge clk);
    ALUOp = op; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || Result !== 64'd0 || Zero !== 1'b1 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset: rdy=%b ov=%b res=%h z=%b ill=%b, need 1 0 0 1 0", in_ready, out_valid, Result, Zero, illegal);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_ops();
    logic [3:0]  ops  [11] = '{4'b0010, 4'b0111, 4'b1000, 4'b1001, 4'b0000, 4'b0001,
                              4'b1100, 4'b0011, 4'b0100, 4'b0101, 4'b0110};
    logic [63:0] va   [11] = '{64'd5, '1, '1, 64'h8000_0000_0000_0000, 64'hF0, 64'hF0,
                              64'd0, 64'hFF, 64'd1, 64'h100, 64'd5};
    logic [63:0] vb   [11] = '{64'd7, 64'd1, 64'd1, 64'd68, 64'h3C, 64'h0F,
                              64'd0, 64'h0F, 64'd65, 64'd4, 64'd7};
    logic [63:0] vexp [11] = '{64'd12, 64'd1, 64'd0, 64'hF800_0000_0000_0000, 64'h30, 64'hFF,
                              '1, 64'hF0, 64'd2, 64'h10, 64'hFFFF_FFFF_FFFF_FFFE};
    for (int i = 0; i < 11; i++) begin
      send(ops[i], va[i], vb[i]);
      checks++;
      if (out_valid !== 1'b1 || Result !== vexp[i] || Zero !== (vexp[i] == 64'd0) ||
          illegal !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL op%0d(%b): ov=%b res=%h z=%b ill=%b rdy=%b, need 1 %h %b 0 1",
                 i, ops[i], out_valid, Result, Zero, illegal, in_ready, vexp[i], vexp[i] == 64'd0);
      end
    end
    // Result/Zero hold while out_valid drops
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || Result !== 64'hFFFF_FFFF_FFFF_FFFE || Zero !== 1'b0) begin
      failures++;
      $display("FAIL hold: ov=%b res=%h z=%b, need 0 fffffffffffffffe 0", out_valid, Result, Zero);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    ALUOp = 4'b0010; a = 64'd5; b = 64'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    ALUOp = 4'b0110; a = 64'h1234; b = 64'h1234;
    checks++;
    if (out_valid !== 1'b1 || Result !== 64'd12 || Zero !== 1'b0) begin
      failures++;
      $display("FAIL b2b_add: ov=%b res=%h z=%b, need 1 c 0", out_valid, Result, Zero);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || Result !== 64'd0 || Zero !== 1'b1) begin
      failures++;
      $display("FAIL b2b_sub: ov=%b res=%h z=%b, need 1 0 1", out_valid, Result, Zero);
    end
  endtask

  task automatic test_illegal();
    send(4'b1111, 64'd3, 64'd3);
    checks++;
    if (out_valid !== 1'b1 || Result !== 64'd0 || Zero !== 1'b1 || illegal !== 1'b1) begin
      failures++;
      $display("FAIL illegal_1111: ov=%b res=%h z=%b ill=%b, need 1 0 1 1", out_valid, Result, Zero, illegal);
    end
    send(4'b0010, 64'd1, 64'd2);
    checks++;
    if (illegal !== 1'b0 || Result !== 64'd3) begin
      failures++;
      $display("FAIL illegal_clear: ill=%b res=%h, need 0 3", illegal, Result);
    end
`ifndef ALU_MULDIV_EN
    send(4'b1010, 64'd3, 64'd3);
    checks++;
    if (out_valid !== 1'b1 || Result !== 64'd0 || illegal !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mul_disabled: ov=%b res=%h ill=%b rdy=%b, need 1 0 1 1", out_valid, Result, illegal, in_ready);
    end
`endif
  endtask

  task automatic test_flush_idle();
    // An op presented together with flush must be dropped
    @(negedge clk);
    ALUOp = 4'b0010; a = 64'd9; b = 64'd9; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || Result === 64'd18) begin
      failures++;
      $display("FAIL flush_idle: ov=%b res=%h, need 0 and not 12", out_valid, Result);
    end
  endtask

`ifdef ALU_MULDIV_EN
  task automatic test_muldiv();
    logic [3:0]  ops  [5] = '{4'b1010, 4'b1011, 4'b1101, 4'b1011, 4'b1101};
    logic [63:0] va   [5] = '{64'd3, 64'd100, 64'd100, 64'd9, 64'd9};
    logic [63:0] vb   [5] = '{'1, 64'd7, 64'd7, 64'd0, 64'd0};
    logic [63:0] vexp [5] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd14, 64'd2, '1, 64'd9};
    int n;
    bit early;
    for (int i = 0; i < 5; i++) begin
      send(ops[i], va[i], vb[i]);
      n = 0; early = 1'b0;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) early = 1'b1;
      while (n < 200) begin
        @(posedge clk); #1;
        n++;
        if (out_valid === 1'b1) break;
        if (in_ready !== 1'b0) early = 1'b1;
      end
      checks++;
      if (n != 64 || early) begin
        failures++;
        $display("FAIL md%0d_latency: cycles=%0d early_ready=%b, need 64 0", i, n, early);
      end
      checks++;
      if (Result !== vexp[i] || Zero !== (vexp[i] == 64'd0) || illegal !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL md%0d_result: res=%h z=%b ill=%b rdy=%b, need %h %b 0 1",
                 i, Result, Zero, illegal, in_ready, vexp[i], vexp[i] == 64'd0);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL md%0d_pulse: ov=%b, need 0", i, out_valid);
      end
    end
  endtask

  // use_reset=0: abort with flush, 1: abort with reset
  task automatic test_abort(input bit use_reset);
    bit seen;
    send(4'b0010, 64'd20, 64'd22);
    send(4'b1011, 64'd100, 64'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    if (use_reset) reset = 1'b1; else flush = 1'b1;
    ALUOp = 4'b0010; a = 64'd4; b = 64'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort%0d_ready: rdy=%b ov=%b, need 1 0", use_reset, in_ready, out_valid);
    end
    checks++;
    if (use_reset ? (Result !== 64'd0 || Zero !== 1'b1 || illegal !== 1'b0)
                  : (Result !== 64'd42)) begin
      failures++;
      $display("FAIL abort%0d_state: res=%h z=%b ill=%b, need %h", use_reset, Result, Zero, illegal,
               use_reset ? 64'd0 : 64'd42);
    end
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL abort%0d_novalid: out_valid seen=1, need 0", use_reset);
    end
    send(4'b0010, 64'd1, 64'd1);
    checks++;
    if (out_valid !== 1'b1 || Result !== 64'd2) begin
      failures++;
      $display("FAIL abort%0d_next_add: ov=%b res=%h, need 1 2", use_reset, out_valid, Result);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ops();
    test_back_to_back();
    test_illegal();
    test_flush_idle();
`ifdef ALU_MULDIV_EN
    test_muldiv();
    test_abort(1'b0);
    test_abort(1'b1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
